// File: rtl/registers.sv
// 32-entry register file with two combinational read ports and one write port.
// r0 is hardwired to zero, and a same-cycle write is forwarded to a matching read port.
module registers #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 has no storage; it always reads as zero.
    logic [DATA_WIDTH-1:0] r_regs [1:DEPTH-1];

    logic                  w_write_en;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    assign w_write_en = rst_n && reg_write && (write_address != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_write_en && (write_address == ADDR_WIDTH'(i))) begin
                    r_regs[i] <= write_data;
                end
            end
        end
    end

    // Port A: array lookup, then write-first bypass, then reset gating.
    always_comb begin
        w_rd_a = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (read_addr_a == ADDR_WIDTH'(i)) begin
                w_rd_a = r_regs[i];
            end
        end
        if (w_write_en && (write_address == read_addr_a)) begin
            w_rd_a = write_data;
        end
        if (!rst_n) begin
            w_rd_a = '0;
        end
    end

    // Port B: same structure as port A, fully independent.
    always_comb begin
        w_rd_b = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (read_addr_b == ADDR_WIDTH'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
        if (w_write_en && (write_address == read_addr_b)) begin
            w_rd_b = write_data;
        end
        if (!rst_n) begin
            w_rd_b = '0;
        end
    end

    assign data_a = w_rd_a;
    assign data_b = w_rd_b;

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the registers block: a behavioural array model checked on
// every falling edge, plus directed literal scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_registers;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] data_a;
    logic [31:0] data_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    logic [31:0] model [32];

    registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_addr_a  (read_addr_a),
        .read_addr_b  (read_addr_b),
        .write_address(write_address),
        .write_data   (write_data),
        .reg_write    (reg_write),
        .data_a       (data_a),
        .data_b       (data_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read value from the architectural rules, using the current inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] addr);
        if (!rst_n) return 32'h0;
        if (addr == 5'd0) return 32'h0;
        if (reg_write && write_address == addr) return write_data;
        return model[addr];
    endfunction

    always @(posedge clk) begin
        if (rst_n && reg_write && write_address != 5'd0)
            model[write_address] = write_data;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("port_a", data_a, exp_rd(read_addr_a));
            chk("port_b", data_b, exp_rd(read_addr_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) begin
            write_address = 5'(i);
            write_data    = 32'(i);
            reg_write     = 1'b1;
            tick();
        end
        reg_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 0; read_addr_a = 0; read_addr_b = 0;
        write_address = 0; write_data = 0; reg_write = 0;
        #1 cmp_en = 1;

        // Reset state, including a write attempt held off by reset.
        tick();
        write_address = 5'd4; write_data = 32'h1234; reg_write = 1; read_addr_a = 5'd4;
        #1 chk("reset_no_bypass", data_a, 32'h0);
        tick();
        reg_write = 0;
        rst_n = 1;
        #1 chk("reset_write_ignored", data_a, 32'h0);
        tick();

        fill();
        read_addr_a = 5'd14; read_addr_b = 5'd17;
        #1 chk("fill_a14", data_a, 32'd14); chk("fill_b17", data_b, 32'd17);
        tick();
        read_addr_a = 5'd20; read_addr_b = 5'd31;
        #1 chk("fill_a20", data_a, 32'd20); chk("fill_b31", data_b, 32'd31);
        tick();
        read_addr_a = 5'd0; read_addr_b = 5'd15;
        #1 chk("fill_a0", data_a, 32'd0); chk("fill_b15", data_b, 32'd15);
        tick();

        // Writes to r0 are discarded and never bypassed.
        write_address = 5'd0; write_data = 32'hDEADBEEF; reg_write = 1; read_addr_a = 5'd0;
        #1 chk("r0_no_bypass", data_a, 32'h0);
        tick();
        reg_write = 0;
        #1 chk("r0_after_write", data_a, 32'h0);
        tick();

        // Write-first bypass on both ports, then the stored value.
        write_address = 5'd9; write_data = 32'd99; reg_write = 1;
        read_addr_a = 5'd9; read_addr_b = 5'd9;
        #1 chk("bypass_a", data_a, 32'd99); chk("bypass_b", data_b, 32'd99);
        tick();
        reg_write = 0;
        #1 chk("stored_a9", data_a, 32'd99);
        tick();

        // Last write wins on consecutive same-address writes.
        write_address = 5'd7; write_data = 32'hAAAA; reg_write = 1; tick();
        write_data = 32'hBBBB; tick();
        reg_write = 0; read_addr_b = 5'd7;
        #1 chk("last_write_wins", data_b, 32'hBBBB);
        tick();

        // Disabled writes leave r5 alone.
        write_address = 5'd5; write_data = 32'd77; reg_write = 0; read_addr_a = 5'd5;
        repeat (3) tick();
        #1 chk("no_write_r5", data_a, 32'd5);
        tick();

        // Mid-cycle asynchronous reset clears reads immediately.
        read_addr_a = 5'd14; read_addr_b = 5'd31;
        #1 rst_n = 0;
        #1 chk("async_rst_a", data_a, 32'h0); chk("async_rst_b", data_b, 32'h0);
        tick();
        rst_n = 1;
        write_address = 5'd3; write_data = 32'h55; reg_write = 1; read_addr_a = 5'd3;
        tick();
        reg_write = 0;
        #1 chk("first_write_after_rst", data_a, 32'h55);
        chk("others_cleared", data_b, 32'h0);
        tick();

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 600; n++) begin
            rst_n         = ($urandom_range(0, 40) != 0);
            reg_write     = 1'($urandom_range(0, 1));
            write_address = 5'($urandom_range(0, 31));
            write_data    = $urandom;
            read_addr_a   = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom_range(0, 31));
            read_addr_b   = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom_range(0, 31));
            tick();
        end
        rst_n = 1; reg_write = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
